// File: rtl/sreg_siso_sipo_pkg.sv
// -----------------------------------------------------------------------------
// sreg_siso_sipo_pkg
//
// Shared definitions for the dual-mode serial shift register.
//   SREG_WIDTH : default number of stages in each shift path.
//   mode_e     : encoding of the 'choice' input. MODE_SISO shifts the
//                serial-in/serial-out path, MODE_SIPO shifts the
//                serial-in/parallel-out path.
// -----------------------------------------------------------------------------
package sreg_siso_sipo_pkg;

    localparam int SREG_WIDTH = 4;

    typedef enum logic {
        MODE_SISO = 1'b0,
        MODE_SIPO = 1'b1
    } mode_e;

endpackage : sreg_siso_sipo_pkg

// File: rtl/sreg_siso_sipo_shift_stage_reg.sv
// -----------------------------------------------------------------------------
// shift_stage_reg
//
// WIDTH-bit left-shift register. New data enters bit 0 and moves one place
// towards the MSB on every enabled rising edge. Reset wins over enable.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears all stages
//   en   : shift enable; when low every stage holds
//   din  : serial data entering stage 0
//   q    : register contents, q[WIDTH-1] is the oldest bit
// -----------------------------------------------------------------------------
module shift_stage_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    // Each stage is built separately so that stage 0 can take din without
    // needing a [WIDTH-2:0] slice, which keeps WIDTH=1 legal.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign w_next[gi] = din;
            end else begin : g_rest
                assign w_next[gi] = r_q[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q[gi] <= 1'b0;
                end else if (en) begin
                    r_q[gi] <= w_next[gi];
                end
            end
        end
    endgenerate

    assign q = r_q;

endmodule : shift_stage_reg

// File: rtl/sreg_siso_sipo.sv
// -----------------------------------------------------------------------------
// sreg_siso_sipo
//
// Dual-mode serial shift register. One serial input feeds two independent
// WIDTH-stage shift paths; 'choice' decides which of them shifts on an edge,
// the other one holds. Each path has its own synchronous reset that acts
// regardless of 'choice'.
//
// Ports:
//   clk     : clock, rising edge
//   resetsi : synchronous active-high reset of the SISO path
//   resetpo : synchronous active-high reset of the SIPO path
//   sinp    : serial data input shared by both paths
//   choice  : 0 (MODE_SISO) shifts SISO, 1 (MODE_SIPO) shifts SIPO
//   sout    : SISO serial output, last SISO stage (registered)
//   out     : SIPO parallel output, SIPO register contents (registered)
// -----------------------------------------------------------------------------
module sreg_siso_sipo
    import sreg_siso_sipo_pkg::*;
#(
    parameter int WIDTH = SREG_WIDTH
) (
    input  logic             clk,
    input  logic             resetsi,
    input  logic             resetpo,
    input  logic             sinp,
    input  logic             choice,
    output logic             sout,
    output logic [WIDTH-1:0] out
);

    logic             w_siso_en;
    logic             w_sipo_en;
    logic [WIDTH-1:0] w_si_q;
    logic [WIDTH-1:0] w_po_q;

    // The two enables are complementary, so exactly one path shifts per edge.
    // An unknown 'choice' is harmless while the resets are asserted because
    // reset has priority inside the shift register.
    assign w_siso_en = (choice == MODE_SISO);
    assign w_sipo_en = (choice == MODE_SIPO);

    shift_stage_reg #(
        .WIDTH (WIDTH)
    ) u_siso (
        .clk (clk),
        .rst (resetsi),
        .en  (w_siso_en),
        .din (sinp),
        .q   (w_si_q)
    );

    shift_stage_reg #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk (clk),
        .rst (resetpo),
        .en  (w_sipo_en),
        .din (sinp),
        .q   (w_po_q)
    );

    assign sout = w_si_q[WIDTH-1];
    assign out  = w_po_q;

    // Only the last SISO stage is visible; the inner stages are pure delay.
    // Folding them into one sink keeps the whole vector accounted for.
    logic w_unused_si;
    assign w_unused_si = ^w_si_q;

endmodule : sreg_siso_sipo

// File: tb/tb_sreg_siso_sipo.sv
// -----------------------------------------------------------------------------
// tb_sreg_siso_sipo
//
// Directed stimulus drives the inputs on the falling edge and pushes the
// hand-computed outputs expected after the following rising edge into a
// queue. An independent monitor samples the outputs shortly after every
// rising edge and compares them against the head of the queue.
// -----------------------------------------------------------------------------
module tb_sreg_siso_sipo;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         resetsi;
    logic         resetpo;
    logic         sinp;
    logic         choice;
    logic         sout;
    logic [W-1:0] out;

    typedef struct {
        string        name;
        logic         sout;
        logic [W-1:0] out;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn      = 0;

    always #5 clk = ~clk;

    sreg_siso_sipo #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .resetsi (resetsi),
        .resetpo (resetpo),
        .sinp    (sinp),
        .choice  (choice),
        .sout    (sout),
        .out     (out)
    );

    // Apply one edge of stimulus and record what the outputs must be after it.
    task automatic step(input string name, input logic rsi, input logic rpo,
                        input logic ch, input logic s,
                        input logic e_sout, input logic [W-1:0] e_out);
        exp_t e;
        @(negedge clk);
        resetsi = rsi;
        resetpo = rpo;
        choice  = ch;
        sinp    = s;
        e.name  = name;
        e.sout  = e_sout;
        e.out   = e_out;
        exp_q.push_back(e);
    endtask

    // Monitor: every rising edge produces a new output state.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                n_checks++;
                if (sout !== e.sout || out !== e.out) begin
                    n_fail++;
                    $display("FAIL txn %0d %s: sout=%b out=%b, required sout=%b out=%b",
                             txn, e.name, sout, out, e.sout, e.out);
                end else begin
                    $display("txn %0d %s: sout=%b out=%b ok", txn, e.name, sout, out);
                end
            end
        end
    end

    initial begin
        resetsi = 1'b1;
        resetpo = 1'b1;
        choice  = 1'b0;
        sinp    = 1'b0;

        // Reset with sinp toggling
        step("reset0", 1, 1, 0, 1, 0, 4'b0000);
        step("reset1", 1, 1, 1, 0, 0, 4'b0000);

        // SISO pulse: single 1 appears on sout after the 4th shifting edge
        step("siso_pulse1", 0, 1, 0, 1, 0, 4'b0000);
        step("siso_pulse2", 0, 1, 0, 0, 0, 4'b0000);
        step("siso_pulse3", 0, 1, 0, 0, 0, 4'b0000);
        step("siso_pulse4", 0, 1, 0, 0, 1, 4'b0000);
        step("siso_pulse5", 0, 1, 0, 0, 0, 4'b0000);
        step("siso_pulse6", 0, 1, 0, 0, 0, 4'b0000);
        step("siso_pulse7", 0, 1, 0, 0, 0, 4'b0000);

        // SIPO walk: a single 1 walks to the MSB and then drops off
        step("sipo_walk1", 1, 0, 1, 1, 0, 4'b0001);
        step("sipo_walk2", 1, 0, 1, 0, 0, 4'b0010);
        step("sipo_walk3", 1, 0, 1, 0, 0, 4'b0100);
        step("sipo_walk4", 1, 0, 1, 0, 0, 4'b1000);
        step("sipo_walk5", 1, 0, 1, 0, 0, 4'b0000);

        // Load 1011 into SIPO
        step("sipo_load1", 1, 0, 1, 1, 0, 4'b0001);
        step("sipo_load2", 1, 0, 1, 0, 0, 4'b0010);
        step("sipo_load3", 1, 0, 1, 1, 0, 4'b0101);
        step("sipo_load4", 1, 0, 1, 1, 0, 4'b1011);

        // Mode hold: SISO shifts 1,1,0,1 while out keeps 1011
        step("hold_siso1", 0, 0, 0, 1, 0, 4'b1011);
        step("hold_siso2", 0, 0, 0, 1, 0, 4'b1011);
        step("hold_siso3", 0, 0, 0, 0, 0, 4'b1011);
        step("hold_siso4", 0, 0, 0, 1, 1, 4'b1011);
        // SIPO shifts once; sout holds at 1 (si_q = 1101)
        step("hold_sout", 0, 0, 1, 0, 1, 4'b0110);
        // resetpo with choice=1 and sinp=1 clears out; SISO untouched
        step("rstpo_mid", 0, 1, 1, 1, 1, 4'b0000);
        // SISO resumes from 1101: remaining stream 1,0,1 emerges
        step("resume1", 0, 0, 0, 0, 1, 4'b0000);
        step("resume2", 0, 0, 0, 0, 0, 4'b0000);
        step("resume3", 0, 0, 0, 0, 1, 4'b0000);
        step("resume4", 0, 0, 0, 0, 0, 4'b0000);

        // resetsi after two SISO shifts of 1: the ones never reach sout
        step("rstsi_a1", 0, 0, 0, 1, 0, 4'b0000);
        step("rstsi_a2", 0, 0, 0, 1, 0, 4'b0000);
        step("rstsi_clr", 1, 0, 0, 1, 0, 4'b0000);
        step("rstsi_b1", 0, 0, 0, 0, 0, 4'b0000);
        step("rstsi_b2", 0, 0, 0, 0, 0, 4'b0000);
        step("rstsi_b3", 0, 0, 0, 0, 0, 4'b0000);
        step("rstsi_b4", 0, 0, 0, 0, 0, 4'b0000);

        // Prepare nonzero state in both paths
        step("prep_po1", 0, 0, 1, 1, 0, 4'b0001);
        step("prep_po2", 0, 0, 1, 1, 0, 4'b0011);
        step("prep_si1", 0, 0, 0, 1, 0, 4'b0011);
        step("prep_si2", 0, 0, 0, 1, 0, 4'b0011);
        step("prep_si3", 0, 0, 0, 1, 0, 4'b0011);
        step("prep_si4", 0, 0, 0, 1, 1, 4'b0011);

        // Both resets with choice unknown clear both paths
        step("both_rst_x", 1, 1, 1'bx, 1, 0, 4'b0000);
        // Release with choice=1: only out moves
        step("release1", 0, 0, 1, 1, 0, 4'b0001);
        step("release2", 0, 0, 1, 0, 0, 4'b0010);

        // Drain the scoreboard with a bounded wait
        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            if (exp_q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: %0d entries left, required 0", exp_q.size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sreg_siso_sipo
